dmi_initiator: RTL and testbench
================================

# dmi_initiator

Requester side of the debug module interface (DMI). Accepts single DMI operations from a host-side command source (test host, UART or JTAG bridge), drives them onto the DM's `dmi_req`/`dmi_resp` handshake, and returns one result per command. Optionally repeats reads until masked bits clear (e.g. polling `abstractcs.busy` or `sbcs.sbbusy`). Enforces a per-request response timeout.

## Interface
Parameters:
- `TimeoutCycles`, default 1024: maximum cycles spent in WAIT before aborting; minimum 2.
- `PollMax`, default 16: maximum DMI reads issued for one poll command; minimum 1.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `host_req_valid_i` in 1 / `host_req_ready_o` out 1: host command handshake.
- `host_req_i` in `dm::dmi_req_t` (41): addr[6:0], op, data[31:0].
- `host_poll_i` in 1: poll mode; sampled with the command, honoured only when op=`DTM_READ`.
- `host_poll_mask_i` in 32: poll completes when `(rdata & mask) == 0`.
- `host_rsp_valid_o` out 1 / `host_rsp_ready_i` in 1: result handshake.
- `host_rsp_data_o` out 32: last DMI response data.
- `host_rsp_err_o` out 2, `dm::dmi_err_e`: 0 OK, 1 DTM error resp, 2 timeout, 3 poll exhausted.
- `dmi_req_valid_o` out 1 / `dmi_req_ready_i` in 1 / `dmi_req_o` out `dm::dmi_req_t`.
- `dmi_resp_valid_i` in 1 / `dmi_resp_ready_o` out 1 / `dmi_resp_i` in `dm::dmi_resp_t` (34).
- `busy_o` out 1: state ≠ IDLE.

## Operation
- FSM states:
  - **IDLE**:
    - `host_req_ready_o`=1.
    - On handshake: latch req, poll flag, mask; clear poll and timeout counters.
    - op=`DTM_NOP` → RESP with data 0, err 0.
    - Otherwise → REQ.
  - **REQ**:
    - `dmi_req_valid_o`=1 with the latched req, held stable until `dmi_req_ready_i`.
    - On handshake → WAIT.
  - **WAIT**:
    - `dmi_resp_ready_o`=1; timeout counter increments each cycle.
    - On response: latch data.
      - resp ≠ `DTM_SUCCESS` → RESP, err 1.
      - Poll active and masked bits nonzero and poll count < PollMax-1 → increment poll count, clear timeout, → REQ.
      - Same masked condition with count = PollMax-1 → RESP, err 3.
      - Otherwise → RESP, err 0.
    - Counter reaches TimeoutCycles-1 with no response → RESP, err 2, data 0.
  - **RESP**:
    - `host_rsp_valid_o`=1; data and err held stable until `host_rsp_ready_i`.
    - On handshake → IDLE.
- A response and a timeout in the same cycle: the response wins.
- `dmi_resp_ready_o` is also 1 in IDLE. Stray responses arriving after a timeout are consumed and discarded; they never reach the host.
- Writes return the DMI response data unmodified.
- No pipelining: at most one DMI request outstanding.

## Timing
- Reset (`rst_ni`=0 at a clock edge): state IDLE. All valid outputs 0, `busy_o` 0, data/err outputs 0, counters 0.
- Reset mid-transaction abandons it; no response is emitted.
- Host accept → `dmi_req_valid_o` high on the next cycle.
- DMI response accepted at edge N → `host_rsp_valid_o` high from cycle N+1.
- Minimum latency, host accept to host response with zero-wait DMI: 3 cycles.
- NOP latency: 1 cycle.
- Poll reissue: next `dmi_req_valid_o` appears one cycle after the response.
- `host_req_ready_o` is combinational from state only. No output depends combinationally on any `*_valid_i` or `*_ready_i`.

## Structure
- Add to `dm` package:
  - `dmi_err_e` (2-bit: `DmiErrNone`, `DmiErrResp`, `DmiErrTimeout`, `DmiErrPoll`).
  - `dmi_init_state_e` (`InitIdle`, `InitReq`, `InitWait`, `InitResp`).
- Reuse the existing `dmi_req_t`, `dmi_resp_t`, `dtm_op_e` and `DTM_SUCCESS`.
- Single flat module; no sub-module. Counter widths are `$clog2(TimeoutCycles)` and `$clog2(PollMax)+1`.

## Test plan
- Write `DMControl` (addr 0x10, data 0x0000_0001), DMI ready and response immediate → one DMI request with matching fields; host response err 0 after 3 cycles.
- Read `DMStatus` (addr 0x11) with resp=2 → host err 1, data equals the returned data.
- Poll read `AbstractCS` (0x16), mask 0x1000, busy for 3 responses then clear → exactly 4 DMI reads; err 0, last data with bit 12 clear.
- Poll with PollMax=16, busy never clears → exactly 16 reads; err 3.
- Withhold `dmi_resp_valid_i`, TimeoutCycles=8 → err 2 exactly 8 cycles after entering WAIT. A later stray response is consumed in IDLE; the next command completes normally.
- NOP command → no DMI activity; response in 1 cycle. `rst_ni` low during WAIT → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/dm.sv
// Debug module package: DMI request/response types plus the initiator's
// result codes and FSM states.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;

    typedef enum logic [1:0] {
        DmiErrNone    = 2'h0,
        DmiErrResp    = 2'h1,
        DmiErrTimeout = 2'h2,
        DmiErrPoll    = 2'h3
    } dmi_err_e;

    typedef enum logic [1:0] {
        InitIdle,
        InitReq,
        InitWait,
        InitResp
    } dmi_init_state_e;

endpackage

// File: rtl/dmi_initiator.sv
// DMI requester: issues one host command at a time onto dmi_req/dmi_resp,
// optionally re-reading until masked bits clear, with a per-request timeout.
module dmi_initiator
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned PollMax       = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        host_req_valid_i,
    output logic        host_req_ready_o,
    input  dmi_req_t    host_req_i,
    input  logic        host_poll_i,
    input  logic [31:0] host_poll_mask_i,
    output logic        host_rsp_valid_o,
    input  logic        host_rsp_ready_i,
    output logic [31:0] host_rsp_data_o,
    output dmi_err_e    host_rsp_err_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output dmi_req_t    dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  dmi_resp_t   dmi_resp_i,
    output logic        busy_o
);

    localparam int unsigned TW = $clog2(TimeoutCycles);
    localparam int unsigned PW = $clog2(PollMax) + 1;
    localparam logic [TW-1:0] TimeoutLast = TW'(TimeoutCycles - 1);
    localparam logic [PW-1:0] PollLast    = PW'(PollMax - 1);

    dmi_init_state_e r_state;
    dmi_init_state_e w_state_next;
    dmi_req_t        r_req;
    logic            r_poll;
    logic [31:0]     r_mask;
    logic [TW-1:0]   r_tmo_cnt;
    logic [PW-1:0]   r_poll_cnt;
    logic [31:0]     r_rsp_data;
    dmi_err_e        r_rsp_err;

    logic w_poll_busy;
    logic w_poll_more;
    logic w_timeout;

    assign w_poll_busy = r_poll && ((dmi_resp_i.data & r_mask) != 32'h0);
    assign w_poll_more = (r_poll_cnt < PollLast);
    assign w_timeout   = (r_tmo_cnt == TimeoutLast);

    assign dmi_req_o       = r_req;
    assign host_rsp_data_o = r_rsp_data;
    assign host_rsp_err_o  = r_rsp_err;
    assign busy_o          = (r_state != InitIdle);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= InitIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Valid/ready semantics on every port pair: a transfer happens on a rising
    // edge where both are high; a raised valid and its payload hold until then.
    // Outputs here depend on state only, never on an incoming valid or ready.
    always_comb begin
        w_state_next     = r_state;
        host_req_ready_o = 1'b0;
        host_rsp_valid_o = 1'b0;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        case (r_state)
            InitIdle: begin
                host_req_ready_o = 1'b1;
                dmi_resp_ready_o = 1'b1;
                if (host_req_valid_i) begin
                    if (host_req_i.op == DTM_NOP) begin
                        w_state_next = InitResp;
                    end else begin
                        w_state_next = InitReq;
                    end
                end
            end
            InitReq: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) begin
                    w_state_next = InitWait;
                end
            end
            InitWait: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) begin
                    if (dmi_resp_i.resp == DTM_SUCCESS && w_poll_busy && w_poll_more) begin
                        w_state_next = InitReq;
                    end else begin
                        w_state_next = InitResp;
                    end
                end else if (w_timeout) begin
                    w_state_next = InitResp;
                end
            end
            InitResp: begin
                host_rsp_valid_o = 1'b1;
                if (host_rsp_ready_i) begin
                    w_state_next = InitIdle;
                end
            end
            default: begin
                w_state_next = InitIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_req      <= '0;
            r_poll     <= 1'b0;
            r_mask     <= '0;
            r_tmo_cnt  <= '0;
            r_poll_cnt <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= DmiErrNone;
        end else begin
            case (r_state)
                InitIdle: begin
                    if (host_req_valid_i) begin
                        r_req      <= host_req_i;
                        r_poll     <= host_poll_i && (host_req_i.op == DTM_READ);
                        r_mask     <= host_poll_mask_i;
                        r_tmo_cnt  <= '0;
                        r_poll_cnt <= '0;
                        r_rsp_data <= '0;
                        r_rsp_err  <= DmiErrNone;
                    end
                end
                InitWait: begin
                    // A response arriving on the timeout cycle takes priority.
                    if (dmi_resp_valid_i) begin
                        r_rsp_data <= dmi_resp_i.data;
                        if (dmi_resp_i.resp != DTM_SUCCESS) begin
                            r_rsp_err <= DmiErrResp;
                        end else if (w_poll_busy && w_poll_more) begin
                            r_poll_cnt <= r_poll_cnt + 1'b1;
                            r_tmo_cnt  <= '0;
                        end else if (w_poll_busy) begin
                            r_rsp_err <= DmiErrPoll;
                        end else begin
                            r_rsp_err <= DmiErrNone;
                        end
                    end else if (w_timeout) begin
                        r_rsp_err  <= DmiErrTimeout;
                        r_rsp_data <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_initiator.sv
// Bench for dmi_initiator: scripted DM responder, expected-result queue and
// a monitor that pops one entry per host response.
module tb_dmi_initiator;
    import dm::*;

    localparam int TIMEOUT     = 8;
    localparam int POLL_MAX    = 16;
    localparam int STRAY_DELAY = 12;
    localparam int N_RANDOM    = 40;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [1:0]  code;
        int          delay;
        int          stall;
        bit          withhold;
        bit          reissue;
    } plan_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        host_req_valid;
    logic        host_req_ready_o;
    dmi_req_t    host_req;
    logic        host_poll;
    logic [31:0] host_poll_mask;
    logic        host_rsp_valid_o;
    logic        host_rsp_ready;
    logic [31:0] host_rsp_data_o;
    dmi_err_e    host_rsp_err_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready;
    dmi_req_t    dmi_req_o;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready_o;
    dmi_resp_t   dmi_resp;
    logic        busy_o;

    dmi_initiator #(.TimeoutCycles(TIMEOUT), .PollMax(POLL_MAX)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .host_req_valid_i (host_req_valid),
        .host_req_ready_o (host_req_ready_o),
        .host_req_i       (host_req),
        .host_poll_i      (host_poll),
        .host_poll_mask_i (host_poll_mask),
        .host_rsp_valid_o (host_rsp_valid_o),
        .host_rsp_ready_i (host_rsp_ready),
        .host_rsp_data_o  (host_rsp_data_o),
        .host_rsp_err_o   (host_rsp_err_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp),
        .busy_o           (busy_o)
    );

    // scoreboard state
    logic [33:0] exp_q[$];
    plan_t       plan_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_reads;
    int          dm_req_count;
    bit          dm_active = 0;
    int          accept_cyc, rsp_hs_cyc, rsp_rise_cyc, wait_enter_cyc;
    int          rsp_mode = 0;   // 0 always ready, 1 random, 2 never

    logic [31:0] gen_val   [POLL_MAX];
    logic [1:0]  gen_code  [POLL_MAX];
    int          gen_delay [POLL_MAX];
    int          gen_stall [POLL_MAX];
    bit          gen_withhold = 0;
    plan_t       mp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    task automatic gen_clear();
        for (int i = 0; i < POLL_MAX; i++) begin
            gen_val[i]   = 32'h0;
            gen_code[i]  = 2'd0;
            gen_delay[i] = 0;
            gen_stall[i] = 0;
        end
        gen_withhold = 0;
    endtask

    // driver: present one command and hold it until the DUT takes it
    task automatic issue(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                         input logic poll, input logic [31:0] mask);
        bit got;
        got = 0;
        host_req.addr  = addr;
        host_req.op    = dtm_op_e'(op);
        host_req.data  = wdata;
        host_poll      = poll;
        host_poll_mask = mask;
        host_req_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (host_req_ready_o) begin
                got = 1;
                accept_cyc = cyc + 1;
            end
        end
        check("host_accept", got, 1);
        @(posedge clk); #1;
        host_req_valid = 1'b0;
        host_req       = dmi_req_t'({$urandom, $urandom});
        host_poll      = 1'($urandom);
        host_poll_mask = $urandom;
    endtask

    // reference model: walk the scripted DM answers the way the host sees them
    task automatic submit(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] wdata,
                          input logic poll, input logic [31:0] mask);
        logic [1:0]  err;
        logic [31:0] rdata;
        bit          eff_poll;
        eff_poll  = poll && (op == 2'd1);
        err       = 2'd0;
        rdata     = 32'h0;
        exp_reads = 0;
        if (op != 2'd0) begin
            for (int i = 0; i < POLL_MAX; i++) begin
                mp.addr = addr; mp.op = op; mp.wdata = wdata;
                mp.data = gen_val[i]; mp.code = gen_code[i];
                mp.delay = gen_delay[i]; mp.stall = gen_stall[i];
                mp.withhold = gen_withhold; mp.reissue = 0;
                exp_reads = i + 1;
                rdata     = gen_val[i];
                if (gen_withhold) begin
                    err = 2'd2; rdata = 32'h0; plan_q.push_back(mp); break;
                end
                if (gen_code[i] != 2'd0) begin
                    err = 2'd1; plan_q.push_back(mp); break;
                end
                if (eff_poll && ((gen_val[i] & mask) != 32'h0)) begin
                    if (i == POLL_MAX - 1) begin
                        err = 2'd3; plan_q.push_back(mp); break;
                    end
                    mp.reissue = 1;
                    plan_q.push_back(mp);
                    continue;
                end
                err = 2'd0;
                plan_q.push_back(mp);
                break;
            end
        end
        exp_q.push_back({err, rdata});
        dm_req_count = 0;
        issue(addr, op, wdata, poll, mask);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0 || dm_active) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check("cmd_done_in_time", k < 3000, 1);
    endtask

    // host response ready driver
    initial begin : rsp_ready_drv
        host_rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rsp_mode)
                0: host_rsp_ready = 1'b1;
                1: host_rsp_ready = ($urandom_range(0, 2) != 0);
                default: host_rsp_ready = 1'b0;
            endcase
        end
    end

    // DM responder following the scripted plans
    initial begin : dm_model
        plan_t    p;
        dmi_req_t seen;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp       = '0;
        @(posedge clk); #1;
        forever begin
            if (!rst_n || !dmi_req_valid_o) begin
                @(posedge clk); #1;
                continue;
            end
            seen = dmi_req_o;
            check("busy_in_req", busy_o, 1);
            if (plan_q.size() == 0) begin
                fail("unplanned_dmi_req", seen);
                p.addr = seen.addr; p.op = seen.op; p.wdata = seen.data;
                p.data = 32'h0; p.code = 2'd0; p.delay = 0; p.stall = 0;
                p.withhold = 0; p.reissue = 0;
            end else begin
                p = plan_q.pop_front();
            end
            dm_active = 1;
            dm_req_count++;
            check("dmi_req_addr", seen.addr, p.addr);
            check("dmi_req_op", seen.op, p.op);
            check("dmi_req_data", seen.data, p.wdata);
            for (int s = 0; s < p.stall; s++) begin
                @(posedge clk); #1;
                check("dmi_req_hold_valid", dmi_req_valid_o, 1);
                check("dmi_req_hold_payload", dmi_req_o, seen);
            end
            dmi_req_ready = 1'b1;
            @(posedge clk); #1;
            dmi_req_ready  = 1'b0;
            wait_enter_cyc = cyc;
            if (p.withhold) begin
                repeat (STRAY_DELAY) begin @(posedge clk); #1; end
                check("stray_resp_ready", dmi_resp_ready_o, 1);
                dmi_resp_valid = 1'b1;
                dmi_resp.data  = $urandom;
                dmi_resp.resp  = 2'd0;
                @(posedge clk); #1;
                dmi_resp_valid = 1'b0;
            end else begin
                repeat (p.delay) begin @(posedge clk); #1; end
                check("dmi_resp_ready", dmi_resp_ready_o, 1);
                dmi_resp_valid = 1'b1;
                dmi_resp.data  = p.data;
                dmi_resp.resp  = p.code;
                @(posedge clk); #1;
                dmi_resp_valid = 1'b0;
                if (p.reissue) check("poll_reissue_next_cycle", dmi_req_valid_o, 1);
            end
            dm_active = 0;
        end
    end

    // monitor: pop one expected result per host response handshake
    initial begin : monitor
        logic        pv, pr;
        logic [31:0] pd;
        logic [1:0]  pe;
        logic [33:0] e;
        pv = 0; pr = 0; pd = 0; pe = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pr = 0;
                continue;
            end
            if (host_rsp_valid_o && !pv) rsp_rise_cyc = cyc;
            if (pv && !pr) begin
                check("rsp_hold_valid", host_rsp_valid_o, 1);
                check("rsp_hold_data", host_rsp_data_o, pd);
                check("rsp_hold_err", host_rsp_err_o, pe);
            end
            if (host_rsp_valid_o && host_rsp_ready) begin
                rsp_hs_cyc = cyc + 1;
                if (exp_q.size() == 0) begin
                    fail("unexpected_host_rsp", {host_rsp_err_o, host_rsp_data_o});
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", host_rsp_data_o, e[31:0]);
                    check("rsp_err", host_rsp_err_o, e[33:32]);
                end
            end
            pv = host_rsp_valid_o;
            pr = host_rsp_ready;
            pd = host_rsp_data_o;
            pe = host_rsp_err_o;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_host_rsp_valid"}, host_rsp_valid_o, 0);
        check({tag, "_dmi_req_valid"}, dmi_req_valid_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_rsp_data"}, host_rsp_data_o, 0);
        check({tag, "_rsp_err"}, host_rsp_err_o, 0);
        check({tag, "_host_req_ready"}, host_req_ready_o, 1);
    endtask

    initial begin : main
        logic [6:0]  a;
        logic [1:0]  op;
        logic [31:0] mask;
        int          busy_n, k;
        host_req_valid = 1'b0;
        host_req       = '0;
        host_poll      = 1'b0;
        host_poll_mask = '0;
        gen_clear();

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_dmi_req", dmi_req_o, 0);
        check("reset_resp_ready", dmi_resp_ready_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // write dmcontrol, zero-wait DM
        gen_clear();
        submit(7'h10, 2'd2, 32'h0000_0001, 1'b0, 32'h0);
        wait_done();
        check("write_latency", rsp_hs_cyc - accept_cyc, 3);
        check("write_reads", dm_req_count, 1);

        // read dmstatus with error response
        gen_clear();
        gen_val[0] = 32'hDEAD_BEEF; gen_code[0] = 2'd2; gen_delay[0] = 2;
        submit(7'h11, 2'd1, 32'h0, 1'b0, 32'h0);
        wait_done();
        check("resp_err_reads", dm_req_count, 1);

        // poll abstractcs: busy three times, then clear
        gen_clear();
        for (int i = 0; i < POLL_MAX; i++) gen_val[i] = 32'h0800_1003;
        gen_val[3] = 32'h0800_0003;
        submit(7'h16, 2'd1, 32'h0, 1'b1, 32'h0000_1000);
        wait_done();
        check("poll_clear_reads", dm_req_count, 4);

        // poll never clears
        gen_clear();
        for (int i = 0; i < POLL_MAX; i++) gen_val[i] = 32'h0000_1000 | i;
        submit(7'h16, 2'd1, 32'h0, 1'b1, 32'h0000_1000);
        wait_done();
        check("poll_exhaust_reads", dm_req_count, POLL_MAX);

        // timeout, then a stray response lands in IDLE
        gen_clear();
        gen_withhold = 1;
        submit(7'h04, 2'd1, 32'h0, 1'b0, 32'h0);
        wait_done();
        check("timeout_latency", rsp_rise_cyc - wait_enter_cyc, TIMEOUT);
        check("timeout_reads", dm_req_count, 1);

        gen_clear();
        gen_val[0] = 32'h1234_5678; gen_delay[0] = 1;
        submit(7'h05, 2'd2, 32'hCAFE_0001, 1'b0, 32'h0);
        wait_done();
        check("after_stray_reads", dm_req_count, 1);

        // NOP: no DMI traffic, one cycle
        gen_clear();
        submit(7'h33, 2'd0, 32'h5555_AAAA, 1'b1, 32'hFFFF_FFFF);
        wait_done();
        check("nop_latency", rsp_hs_cyc - accept_cyc, 1);
        check("nop_reads", dm_req_count, 0);

        // reset during WAIT abandons the command
        gen_clear();
        gen_withhold = 1;
        submit(7'h17, 2'd1, 32'h0, 1'b0, 32'h0);
        k = 0;
        while (!(busy_o && dmi_resp_ready_o) && k < 50) begin @(posedge clk); #1; k++; end
        check("reached_wait", k < 50, 1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_wait");
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen_withhold = 0;
        wait_done();
        check("rst_wait_reads", dm_req_count, 1);

        // reset while a nonzero result is held in RESP
        gen_clear();
        gen_val[0] = 32'hA5A5_0001; gen_code[0] = 2'd3;
        rsp_mode = 2;
        submit(7'h20, 2'd1, 32'h0, 1'b0, 32'h0);
        k = 0;
        while (!host_rsp_valid_o && k < 50) begin @(posedge clk); #1; k++; end
        check("held_rsp_data", host_rsp_data_o, 32'hA5A5_0001);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst_resp");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_mode = 0;
        wait_done();

        // randomized commands
        rsp_mode = 1;
        for (int n = 0; n < N_RANDOM; n++) begin
            gen_clear();
            a      = 7'($urandom);
            op     = 2'($urandom_range(0, 2));
            mask   = ($urandom_range(0, 1) != 0) ? (32'h1 << $urandom_range(0, 31)) : ($urandom | 32'h1);
            busy_n = $urandom_range(0, POLL_MAX + 2);
            for (int i = 0; i < POLL_MAX; i++) begin
                gen_val[i]   = (i < busy_n) ? ($urandom | mask) : ($urandom & ~mask);
                gen_code[i]  = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(2, 3)) : 2'd0;
                gen_delay[i] = $urandom_range(0, 3);
                gen_stall[i] = $urandom_range(0, 2);
            end
            submit(a, op, $urandom, 1'($urandom_range(0, 1)), mask);
            wait_done();
            check("rand_reads", dm_req_count, exp_reads);
        end
        rsp_mode = 0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
